// File: rtl/main_fsm_pkg.sv
// Shared RV32I-subset controller definitions: opcodes, FSM states, ALU operations and datapath selects.
`timescale 1ns/1ps
package pa_riscv;

    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU_OUT_Q  = 2'd0,
        RES_DATA_Q     = 2'd1,
        RES_ALU_RESULT = 2'd2
    } result_sel_e;

    typedef enum logic [1:0] {
        A_PC     = 2'd0,
        A_OLD_PC = 2'd1,
        A_RD1    = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RD2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } b_sel_e;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_RTYPE = 2'd1,
        CLS_ITYPE = 2'd2
    } op_class_e;

    function automatic op_class_e op_class(input logic [6:0] opcode);
        case (opcode)
            OPC_RTYPE: op_class = CLS_RTYPE;
            OPC_ITYPE: op_class = CLS_ITYPE;
            default:   op_class = CLS_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/main_fsm_alu_decoder.sv
// Combinational ALU operation decode from instruction class and funct fields.
`timescale 1ns/1ps
module aluDecoder
    import pa_riscv::*;
(
    input  op_class_e  i_opClass,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7bit5,
    output alu_op_e    o_aluLogicOperation
);

    always_comb begin
        o_aluLogicOperation = ALU_ADD;
        case (i_funct3)
            // Only R-type honours bit 30; for addi that bit belongs to the immediate.
            3'b000:  o_aluLogicOperation = (i_opClass == CLS_RTYPE && i_funct7bit5) ? ALU_SUB : ALU_ADD;
            3'b010:  o_aluLogicOperation = ALU_SLT;
            3'b110:  o_aluLogicOperation = ALU_OR;
            3'b111:  o_aluLogicOperation = ALU_AND;
            default: o_aluLogicOperation = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multi-cycle Moore controller for the RV32I-subset core; drives every datapath enable and select.
`timescale 1ns/1ps
module main_fsm
    import pa_riscv::*;
(
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic [6:0] i_operand,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7bit5,
    input  logic       i_zeroFlag,
    output logic       o_pcWriteEn,
    output logic       o_instructionRegWrite,
    output logic       o_addressSrc,
    output logic       o_memWriteEn,
    output logic       o_regWriteEn,
    output logic [1:0] o_resultSel,
    output logic [1:0] o_aluInputASel,
    output logic [1:0] o_aluInputBSel,
    output logic [3:0] o_aluLogicOperation,
    output logic       o_illegalInstruction
);

    state_e      state_q, state_d;
    alu_op_e     dec_op;
    alu_op_e     alu_op;
    result_sel_e result_sel;
    a_sel_e      a_sel;
    b_sel_e      b_sel;

    aluDecoder u_alu_decoder (
        .i_opClass           (op_class(i_operand)),
        .i_funct3            (i_funct3),
        .i_funct7bit5        (i_funct7bit5),
        .o_aluLogicOperation (dec_op)
    );

    always_ff @(posedge i_clk) begin
        if (i_srst) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d               = state_q;
        o_pcWriteEn           = 1'b0;
        o_instructionRegWrite = 1'b0;
        o_addressSrc          = 1'b0;
        o_memWriteEn          = 1'b0;
        o_regWriteEn          = 1'b0;
        o_illegalInstruction  = 1'b0;
        result_sel            = RES_ALU_RESULT;
        a_sel                 = A_PC;
        b_sel                 = B_FOUR;
        alu_op                = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                o_instructionRegWrite = 1'b1;
                o_pcWriteEn           = 1'b1;
                state_d               = S_DECODE;
            end
            S_DECODE: begin
                // Branch target lands in the ALU output register for use by BEQ.
                a_sel = A_OLD_PC;
                b_sel = B_IMM;
                case (i_operand)
                    OPC_LW, OPC_SW: state_d = S_MEMADR;
                    OPC_RTYPE:      state_d = S_EXECUTER;
                    OPC_ITYPE:      state_d = S_EXECUTEI;
                    OPC_BEQ:        state_d = S_BEQ;
                    OPC_JAL:        state_d = S_JAL;
                    default: begin
                        state_d              = S_FETCH;
                        o_illegalInstruction = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                a_sel   = A_RD1;
                b_sel   = B_IMM;
                state_d = (i_operand == OPC_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                o_addressSrc = 1'b1;
                result_sel   = RES_ALU_OUT_Q;
                state_d      = S_MEMWB;
            end
            S_MEMWB: begin
                result_sel   = RES_DATA_Q;
                o_regWriteEn = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                o_addressSrc = 1'b1;
                result_sel   = RES_ALU_OUT_Q;
                o_memWriteEn = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXECUTER: begin
                a_sel   = A_RD1;
                b_sel   = B_RD2;
                alu_op  = dec_op;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                a_sel   = A_RD1;
                b_sel   = B_IMM;
                alu_op  = dec_op;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                result_sel   = RES_ALU_OUT_Q;
                o_regWriteEn = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQ: begin
                a_sel       = A_RD1;
                b_sel       = B_RD2;
                alu_op      = ALU_SUB;
                result_sel  = RES_ALU_OUT_Q;
                o_pcWriteEn = i_zeroFlag;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                a_sel       = A_OLD_PC;
                b_sel       = B_FOUR;
                result_sel  = RES_ALU_OUT_Q;
                o_pcWriteEn = 1'b1;
                state_d     = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset overrides the current state so an aborted instruction cannot write anything.
        if (i_srst) begin
            state_d               = S_FETCH;
            o_pcWriteEn           = 1'b0;
            o_instructionRegWrite = 1'b0;
            o_addressSrc          = 1'b0;
            o_memWriteEn          = 1'b0;
            o_regWriteEn          = 1'b0;
            o_illegalInstruction  = 1'b0;
            result_sel            = RES_ALU_RESULT;
            a_sel                 = A_PC;
            b_sel                 = B_FOUR;
            alu_op                = ALU_ADD;
        end
    end

    assign o_resultSel         = result_sel;
    assign o_aluInputASel      = a_sel;
    assign o_aluInputBSel      = b_sel;
    assign o_aluLogicOperation = alu_op;

endmodule

// File: doc/main_fsm.md
# main_fsm

Multi-cycle main controller for the RV32I subset core (lw, sw, add/sub/and/or/slt, addi/andi/ori/slti, beq, jal). It sequences the shared instruction/data memory, instruction and old-PC registers, register file, ALU and PC through a Moore state machine, one instruction at a time. It sits beside the datapath in the multi-cycle top and drives every enable and mux select. It also decodes the ALU operation from opcode and funct fields.

## Interface
Parameters: none.

- i_clk  in  1  core clock; single clock domain
- i_srst  in  1  reset, synchronous, active-high
- i_operand  in  7  opcode, from instruction register bits [6:0]
- i_funct3  in  3  instruction register bits [14:12]
- i_funct7bit5  in  1  instruction register bit 30
- i_zeroFlag  in  1  combinational ALU zero flag
- o_pcWriteEn  out  1  PC register load enable
- o_instructionRegWrite  out  1  load instruction register and old-PC register
- o_addressSrc  out  1  memory address select: 0 = PC, 1 = registered ALU output
- o_memWriteEn  out  1  memory write strobe
- o_regWriteEn  out  1  register file write enable
- o_resultSel  out  2  result mux select: ALU_OUT_Q / DATA_Q / ALU_RESULT
- o_aluInputASel  out  2  ALU A select: PC / OLD_PC / REG_READ_DATA_1
- o_aluInputBSel  out  2  ALU B select: REG_READ_DATA_2 / IMMEDIATE_EXTENDED / FOUR
- o_aluLogicOperation  out  4  ALU operation: ADD / SUB / AND / OR / SLT
- o_illegalInstruction  out  1  one-cycle pulse on unsupported opcode in DECODE

## Operation
- States:
  - FETCH: addressSrc=0, irWrite=1, A=PC, B=FOUR, ADD, result=ALU_RESULT, pcWriteEn=1.
  - DECODE: A=OLD_PC, B=IMM, ADD. Precomputes the branch target into the ALU output register.
  - MEMADR: A=RD1, B=IMM, ADD.
  - MEMREAD: addressSrc=1, result=ALU_OUT_Q.
  - MEMWB: result=DATA_Q, regWriteEn=1.
  - MEMWRITE: addressSrc=1, result=ALU_OUT_Q, memWriteEn=1.
  - EXECUTER: A=RD1, B=RD2, op from the ALU decoder.
  - EXECUTEI: A=RD1, B=IMM, op from the ALU decoder.
  - ALUWB: result=ALU_OUT_Q, regWriteEn=1.
  - BEQ: A=RD1, B=RD2, SUB, result=ALU_OUT_Q, pcWriteEn=i_zeroFlag.
  - JAL: A=OLD_PC, B=FOUR, ADD, result=ALU_OUT_Q, pcWriteEn=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for lw/sw, EXECUTER for R-type, EXECUTEI for I-ALU, BEQ for beq, JAL for jal. Any other opcode → FETCH and pulses o_illegalInstruction.
  - MEMADR→MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD→MEMWB.
  - EXECUTER, EXECUTEI and JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
- Unlisted outputs in any state: enables 0, selects at their FETCH values, operation ADD.
- ALU decode:
  - funct3 000 → ADD, except R-type with funct7bit5=1 → SUB.
  - funct3 010 → SLT, 110 → OR, 111 → AND.
  - Any other funct3 → ADD, no illegal flag.
  - I-type ignores funct7bit5: addi is always ADD.

## Timing
- Moore outputs decoded from the state register. The only exception is o_pcWriteEn in BEQ, which is combinational on i_zeroFlag.
- The state register updates on the rising edge of i_clk.
- Cycles per instruction, FETCH inclusive:
  - lw 5.
  - sw, R-type, I-ALU and jal 4.
  - beq 3, taken or not.
  - Illegal opcode 2.
- Reset:
  - i_srst high loads FETCH on the next edge.
  - While i_srst is high, all enables and o_illegalInstruction are forced to 0 and selects hold their FETCH values.
  - The first FETCH executes in the cycle after i_srst deasserts.
- Reset asserted mid-instruction aborts it. No memory or register write occurs from the asserting cycle onward.
- Exactly one write strobe class is active per cycle. o_memWriteEn and o_regWriteEn are never high together.

## Structure
- Shared package pa_riscv holds:
  - opcode constants (LW, SW, RTYPE, ITYPE, BEQ, JAL);
  - the state enum;
  - the operation enum: ADD=0, SUB=1, AND=2, OR=3, SLT=4;
  - the select enums for resultSel, aluInputASel and aluInputBSel.
- Sub-module aluDecoder: combinational, inputs operand class, funct3 and funct7bit5; output aluLogicOperation.

## Test plan
- Reset held 3 cycles, then released with add x3,x1,x2 (R-type, funct3 000, funct7bit5 0) supplied:
  - during reset, every enable is 0;
  - after release, state trace is FETCH, DECODE, EXECUTER, ALUWB, FETCH;
  - EXECUTER drives op=ADD;
  - regWriteEn=1 only in ALUWB.
- sub (funct7bit5=1) → op SUB in EXECUTER. addi with imm bit 10 set (funct7bit5=1) → op ADD in EXECUTEI, B select = IMMEDIATE_EXTENDED.
- lw then sw:
  - lw takes 5 cycles, with addressSrc=1 in MEMREAD and regWriteEn in MEMWB, result=DATA_Q;
  - sw takes 4 cycles, with memWriteEn high only in MEMWRITE.
- beq:
  - zeroFlag=1 in BEQ → pcWriteEn=1;
  - zeroFlag=0 → pcWriteEn=0;
  - both cases return to FETCH after 3 cycles.
- jal → DECODE, JAL (pcWriteEn=1, A=OLD_PC, B=FOUR), ALUWB (regWriteEn=1), FETCH.
- Opcode 0x7F → FETCH, DECODE (illegal pulse=1 for one cycle), FETCH. Reset asserted during MEMWRITE → memWriteEn=0 that cycle; FETCH follows release.
